// File: rtl/seq_sort_pkg.sv
// ----------------------------------------------------------------------------
// seq_sort_pkg
//   Shared definitions for the sequential sorter and its display neighbours.
//   - sort_state_t : sorter FSM states (IDLE, LOAD, PASS, FINISH)
//   - hex_to_seg7  : hex digit to 7-segment pattern, used by the display scanner
//                    that sits outside the sorter. Bit order {g,f,e,d,c,b,a},
//                    1 = segment lit.
// ----------------------------------------------------------------------------
package seq_sort_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PASS   = 2'd2,
        ST_FINISH = 2'd3
    } sort_state_t;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] i_hex);
        logic [6:0] w_seg;
        case (i_hex)
            4'h0:    w_seg = 7'h3F;
            4'h1:    w_seg = 7'h06;
            4'h2:    w_seg = 7'h5B;
            4'h3:    w_seg = 7'h4F;
            4'h4:    w_seg = 7'h66;
            4'h5:    w_seg = 7'h6D;
            4'h6:    w_seg = 7'h7D;
            4'h7:    w_seg = 7'h07;
            4'h8:    w_seg = 7'h7F;
            4'h9:    w_seg = 7'h6F;
            4'hA:    w_seg = 7'h77;
            4'hB:    w_seg = 7'h7C;
            4'hC:    w_seg = 7'h39;
            4'hD:    w_seg = 7'h5E;
            4'hE:    w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/seq_sort_cmp.sv
// ----------------------------------------------------------------------------
// seq_sort_cmp
//   Combinational compare stage of the bubble sorter.
//   Ports:
//     a, b     in  DATA_W  left / right operand
//     dir      in  1       0 = ascending, 1 = descending
//     swap     out 1       operands are out of order for dir (equal never swaps)
//     min_v    out DATA_W  smaller operand
//     max_v    out DATA_W  larger operand
// ----------------------------------------------------------------------------
module seq_sort_cmp #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              dir,
    output logic              swap,
    output logic [DATA_W-1:0] min_v,
    output logic [DATA_W-1:0] max_v
);

    logic w_a_lt_b;
    logic w_a_gt_b;

    assign w_a_lt_b = (a < b);
    assign w_a_gt_b = (a > b);

    // Strict comparisons keep equal keys in place, which makes the sort stable.
    assign swap  = dir ? w_a_lt_b : w_a_gt_b;
    assign min_v = w_a_lt_b ? a : b;
    assign max_v = w_a_lt_b ? b : a;

endmodule

// File: rtl/seq_sorter_param.sv
// ----------------------------------------------------------------------------
// seq_sorter_param
//   Sequential bubble sorter: DEPTH user-written entries of DATA_W bits, sorted
//   on request into a separate buffer, one compare per clock, stopping after
//   the first swap-free pass.
//   Ports:
//     clock, reset      system clock, synchronous active-high reset
//     wr_en, sel, num   entry write (registered once before use)
//     sort              start request, rising edge detected after registering
//     descending        order for the next run, sampled in LOAD
//     show_sorted       read view: 1 = sorted buffer (if valid), 0 = raw
//     rd_idx, rd_data   combinational read port
//     busy, done        run in progress / one-cycle end-of-run pulse
//     sorted_valid      sorted buffer matches the raw entries
//     swap_count        swaps of the last run, saturating
// ----------------------------------------------------------------------------
module seq_sorter_param
    import seq_sort_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  sel,
    input  logic [DATA_W-1:0] num,
    input  logic              sort,
    input  logic              descending,
    input  logic              show_sorted,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              sorted_valid,
    output logic [CNT_W-1:0]  swap_count
);

    localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 2);

    sort_state_t       r_state;
    sort_state_t       w_state_nxt;

    logic              r_wr_en;
    logic [IDX_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_num;
    logic              r_sort;
    logic              r_sort_q;

    logic [DATA_W-1:0] r_raw    [DEPTH];
    logic [DATA_W-1:0] r_sorted [DEPTH];

    logic              r_dir;
    logic [IDX_W-1:0]  r_idx;
    logic              r_pass_swapped;
    logic [CNT_W-1:0]  r_swap_count;
    logic              r_stale;
    logic              r_sorted_valid;

    logic              w_sort_rise;
    logic              w_wr_ok;
    logic              w_busy;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_swap;
    logic              w_pass_swapped;
    logic [DATA_W-1:0] w_min;
    logic [DATA_W-1:0] w_max;

    assign w_sort_rise    = r_sort && !r_sort_q;
    assign w_wr_ok        = r_wr_en && ({1'b0, r_sel} < DEPTH_EXT);
    assign w_idx_nxt      = r_idx + IDX_W'(1);
    assign w_pass_swapped = r_pass_swapped || w_swap;

    seq_sort_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .a     (r_sorted[r_idx]),
        .b     (r_sorted[w_idx_nxt]),
        .dir   (r_dir),
        .swap  (w_swap),
        .min_v (w_min),
        .max_v (w_max)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_sort_rise) w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_PASS;
            ST_PASS:   if (r_idx == LAST_IDX && !w_pass_swapped) w_state_nxt = ST_FINISH;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_LOAD, ST_PASS: w_busy = 1'b1;
            ST_FINISH:        done   = 1'b1;
            default:          ;
        endcase
    end

    assign busy = w_busy;

    // ---------------- datapath ----------------
    // NOTE: the entry arrays are small register banks, not RAM macros, so they
    // are cleared by reset like any other state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_en        <= 1'b0;
            r_sel          <= '0;
            r_num          <= '0;
            r_sort         <= 1'b0;
            r_sort_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_raw[i]    <= '0;
                r_sorted[i] <= '0;
            end
            r_dir          <= 1'b0;
            r_idx          <= '0;
            r_pass_swapped <= 1'b0;
            r_swap_count   <= '0;
            r_stale        <= 1'b0;
            r_sorted_valid <= 1'b0;
        end else begin
            r_wr_en  <= wr_en;
            r_sel    <= sel;
            r_num    <= num;
            r_sort   <= sort;
            r_sort_q <= r_sort;

            if (w_wr_ok) r_raw[r_sel] <= r_num;

            case (r_state)
                ST_LOAD: begin
                    r_sorted       <= r_raw;
                    r_dir          <= descending;
                    r_idx          <= '0;
                    r_pass_swapped <= 1'b0;
                    r_swap_count   <= '0;
                    r_stale        <= 1'b0;
                    r_sorted_valid <= 1'b0;
                end
                ST_PASS: begin
                    // NOTE: non-blocking assignments let both entries read their
                    // old values, so the pair exchanges in a single clock.
                    if (w_swap) begin
                        r_sorted[r_idx]     <= r_dir ? w_max : w_min;
                        r_sorted[w_idx_nxt] <= r_dir ? w_min : w_max;
                        if (r_swap_count != '1) r_swap_count <= r_swap_count + CNT_W'(1);
                    end
                    if (r_idx == LAST_IDX) begin
                        r_idx          <= '0;
                        r_pass_swapped <= 1'b0;
                    end else begin
                        r_idx          <= w_idx_nxt;
                        r_pass_swapped <= w_pass_swapped;
                    end
                end
                ST_FINISH: r_sorted_valid <= !r_stale;
                default:   ;
            endcase

            // A write always invalidates the sorted view; during a run it also
            // marks the snapshot as stale so FINISH will not re-validate it.
            if (w_wr_ok) begin
                r_sorted_valid <= 1'b0;
                if (w_busy) r_stale <= 1'b1;
            end
        end
    end

    assign sorted_valid = r_sorted_valid;
    assign swap_count   = r_swap_count;

    // ---------------- read port ----------------
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < DEPTH_EXT) begin
            if (show_sorted && r_sorted_valid) rd_data = r_sorted[rd_idx];
            else                               rd_data = r_raw[rd_idx];
        end
    end

endmodule

// File: tb/tb_seq_sorter_param.sv
// ----------------------------------------------------------------------------
// tb_seq_sorter_param
//   Self-checking bench for seq_sorter_param (DATA_W=4, DEPTH=4, CNT_W=8).
//   Table of hand-derived vectors, hand sequences for multi-cycle corner cases,
//   and random vectors checked against a rank/inversion-count reference model.
// ----------------------------------------------------------------------------
module tb_seq_sorter_param;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int IW    = 2;
    localparam int CW    = 8;

    typedef logic [DW-1:0] vec_t [DEPTH];

    typedef struct {
        vec_t vals;
        logic dir;
        vec_t exp_sorted;
        int   exp_swaps;
        int   exp_lat;
    } vec_rec_t;

    logic          clock;
    logic          reset;
    logic          wr_en;
    logic [IW-1:0] sel;
    logic [DW-1:0] num;
    logic          sort;
    logic          descending;
    logic          show_sorted;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          sorted_valid;
    logic [CW-1:0] swap_count;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t m_raw;

    seq_sorter_param #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .sel          (sel),
        .num          (num),
        .sort         (sort),
        .descending   (descending),
        .show_sorted  (show_sorted),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .sorted_valid (sorted_valid),
        .swap_count   (swap_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: stable order by rank, swaps = strict inversions, passes =
    // (largest count of out-of-order predecessors of any element) + 1 clean pass.
    function automatic void model_sort(input vec_t a, input logic dir,
                                       output vec_t s, output int swaps, output int lat);
        int k_max;
        k_max = 0;
        swaps = 0;
        for (int i = 0; i < DEPTH; i++) begin
            int rank;
            int k;
            rank = 0;
            k    = 0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i) begin
                    if (dir ? (a[j] > a[i]) : (a[j] < a[i])) rank++;
                    else if (a[j] == a[i] && j < i)           rank++;
                    if (j < i && (dir ? (a[j] < a[i]) : (a[j] > a[i]))) k++;
                end
            end
            s[rank] = a[i];
            swaps += k;
            if (k > k_max) k_max = k;
        end
        if (swaps > 255) swaps = 255;
        lat = 2 + (k_max + 1) * (DEPTH - 1);
    endfunction

    task automatic write_entry(input int idx, input logic [DW-1:0] v);
        wr_en = 1'b1;
        sel   = IW'(idx);
        num   = v;
        tick();
        wr_en = 1'b0;
        m_raw[idx] = v;
    endtask

    task automatic load_all(input vec_t v);
        for (int i = 0; i < DEPTH; i++) write_entry(i, v[i]);
        tick();
    endtask

    task automatic check_view(input string tag, input logic show, input vec_t exp);
        show_sorted = show;
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IW'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), 32'(rd_data), 32'(exp[i]));
        end
        show_sorted = 1'b0;
        tick();
    endtask

    // Raises sort and waits for done; lat = cycles from registered edge to done.
    task automatic run_sort(input logic dir, output int lat);
        descending = dir;
        sort       = 1'b1;
        lat        = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            wr_en = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        sort = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [3:0] a3);
        vec_t v;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        return v;
    endfunction

    initial begin
        vec_rec_t tbl [6];
        vec_t     zero_v;
        vec_t     exp_s;
        int       lat;
        int       exp_sw;
        int       exp_lat;
        int       dones;
        logic     dir_r;

        tbl[0] = '{vals: mk(4'h3, 4'h1, 4'h2, 4'h0), dir: 1'b0, exp_sorted: mk(4'h0, 4'h1, 4'h2, 4'h3), exp_swaps: 5, exp_lat: 14};
        tbl[1] = '{vals: mk(4'h1, 4'h2, 4'h3, 4'h4), dir: 1'b0, exp_sorted: mk(4'h1, 4'h2, 4'h3, 4'h4), exp_swaps: 0, exp_lat: 5};
        tbl[2] = '{vals: mk(4'h9, 4'h9, 4'h2, 4'h9), dir: 1'b1, exp_sorted: mk(4'h9, 4'h9, 4'h9, 4'h2), exp_swaps: 1, exp_lat: 8};
        tbl[3] = '{vals: mk(4'h0, 4'h1, 4'h2, 4'h3), dir: 1'b1, exp_sorted: mk(4'h3, 4'h2, 4'h1, 4'h0), exp_swaps: 6, exp_lat: 14};
        tbl[4] = '{vals: mk(4'h5, 4'h5, 4'h5, 4'h5), dir: 1'b0, exp_sorted: mk(4'h5, 4'h5, 4'h5, 4'h5), exp_swaps: 0, exp_lat: 5};
        tbl[5] = '{vals: mk(4'hF, 4'h0, 4'hF, 4'h0), dir: 1'b0, exp_sorted: mk(4'h0, 4'h0, 4'hF, 4'hF), exp_swaps: 3, exp_lat: 11};
        zero_v = mk(4'h0, 4'h0, 4'h0, 4'h0);
        m_raw  = zero_v;

        reset = 1'b1; wr_en = 1'b0; sel = '0; num = '0; sort = 1'b0;
        descending = 1'b0; show_sorted = 1'b0; rd_idx = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(sorted_valid), 0);
        check("rst_swaps", 32'(swap_count), 0);
        check_view("rst_raw", 1'b0, zero_v);
        check_view("rst_sortview", 1'b1, zero_v);

        // Table-driven runs
        for (int t = 0; t < 6; t++) begin
            load_all(tbl[t].vals);
            run_sort(tbl[t].dir, lat);
            check($sformatf("t%0d_latency", t), 32'(lat), 32'(tbl[t].exp_lat));
            check($sformatf("t%0d_swaps", t), 32'(swap_count), 32'(tbl[t].exp_swaps));
            tick();
            check($sformatf("t%0d_done_pulse", t), 32'(done), 0);
            check($sformatf("t%0d_busy", t), 32'(busy), 0);
            check($sformatf("t%0d_valid", t), 32'(sorted_valid), 1);
            check_view($sformatf("t%0d_sorted", t), 1'b1, tbl[t].exp_sorted);
            check_view($sformatf("t%0d_raw", t), 1'b0, tbl[t].vals);
        end

        // Write in the same cycle as the sort edge: LOAD must copy the new value
        load_all(mk(4'h4, 4'h3, 4'h2, 4'h1));
        wr_en = 1'b1; sel = 2'd0; num = 4'h0;
        m_raw[0] = 4'h0;
        run_sort(1'b0, lat);
        model_sort(m_raw, 1'b0, exp_s, exp_sw, exp_lat);
        check("same_cycle_latency", 32'(lat), 32'(exp_lat));
        check("same_cycle_swaps", 32'(swap_count), 32'(exp_sw));
        tick();
        check("same_cycle_valid", 32'(sorted_valid), 1);
        check_view("same_cycle_sorted", 1'b1, exp_s);

        // Write mid-sort: run finishes on its snapshot, result marked invalid
        load_all(mk(4'h3, 4'h1, 4'h2, 4'h0));
        descending = 1'b0;
        sort = 1'b1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == 4) begin
                wr_en = 1'b1; sel = 2'd2; num = 4'hF;
            end
            tick();
            wr_en = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        sort = 1'b0;
        m_raw[2] = 4'hF;
        check("midwr_latency", 32'(lat), 14);
        check("midwr_swaps", 32'(swap_count), 5);
        tick();
        check("midwr_valid", 32'(sorted_valid), 0);
        check_view("midwr_view", 1'b1, m_raw);

        // Reset during PASS aborts the run
        load_all(mk(4'h3, 4'h2, 4'h1, 4'h0));
        descending = 1'b0;
        sort = 1'b1;
        repeat (5) tick();
        check("pre_reset_busy", 32'(busy), 1);
        reset = 1'b1;
        sort  = 1'b0;
        tick();
        reset = 1'b0;
        m_raw = zero_v;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_valid", 32'(sorted_valid), 0);
        check("abort_swaps", 32'(swap_count), 0);
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            if (done) dones++;
            tick();
        end
        check("abort_no_done", 32'(dones), 0);
        check_view("abort_raw", 1'b0, zero_v);
        check_view("abort_sortview", 1'b1, zero_v);

        // sort held high for 20 cycles: exactly one run
        load_all(mk(4'h3, 4'h2, 4'h1, 4'h0));
        descending = 1'b0;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            sort = (n <= 20);
            tick();
            if (done) dones++;
        end
        sort = 1'b0;
        check("held_runs", 32'(dones), 1);
        check("held_valid", 32'(sorted_valid), 1);
        check_view("held_sorted", 1'b1, mk(4'h0, 4'h1, 4'h2, 4'h3));

        // Extra sort pulses while busy are ignored
        load_all(mk(4'h3, 4'h2, 4'h1, 4'h0));
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            sort = (n == 1 || n == 5 || n == 9);
            tick();
            if (done) dones++;
        end
        sort = 1'b0;
        check("pulse_runs", 32'(dones), 1);
        check("pulse_swaps", 32'(swap_count), 6);

        // Random vectors against the reference model
        for (int r = 0; r < 25; r++) begin
            vec_t rv;
            for (int i = 0; i < DEPTH; i++) rv[i] = DW'($urandom_range(0, 15));
            dir_r = 1'($urandom_range(0, 1));
            load_all(rv);
            model_sort(rv, dir_r, exp_s, exp_sw, exp_lat);
            run_sort(dir_r, lat);
            check($sformatf("rnd%0d_latency", r), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_swaps", r), 32'(swap_count), 32'(exp_sw));
            tick();
            check($sformatf("rnd%0d_valid", r), 32'(sorted_valid), 1);
            check_view($sformatf("rnd%0d_sorted", r), 1'b1, exp_s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
